// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
//   Shared definitions for the two-master memory arbiter:
//   - FSM state encoding (IDLE/REQ/BUSY/DRAIN)
//   - default data width, selected by the RV64I define
//   - small request-qualification helpers
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

`ifdef RV64I
  localparam int DEFAULT_DATA_SIZE = 64;
`else
  localparam int DEFAULT_DATA_SIZE = 32;
`endif

  // A master is requesting when either enable is high.
  function automatic logic req_of(input logic rd_en, input logic wr_en);
    return rd_en | wr_en;
  endfunction

  // rd_en wins over wr_en: a simultaneous rd/wr is treated as a read.
  function automatic logic wr_qualify(input logic rd_en, input logic wr_en);
    return wr_en & ~rd_en;
  endfunction

endpackage

// File: rtl/memory_arbiter_watchdog_counter.sv
// watchdog_counter
//   Counts cycles while enabled and flags expiry on the cycle the count
//   reaches TIMEOUT-1, i.e. in the TIMEOUT-th enabled cycle after a clear.
// Ports:
//   clock   in  system clock
//   reset   in  synchronous active-high reset
//   clear   in  zero the count (takes priority over enable)
//   enable  in  count this cycle
//   expired out combinational, high in the last allowed enabled cycle
module watchdog_counter
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [CW-1:0] wd_cnt_q;
  logic [CW-1:0] wd_cnt_d;

  // Next count: clear wins, otherwise increment while enabled.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear) begin
      wd_cnt_d = '0;
    end else if (enable) begin
      wd_cnt_d = wd_cnt_q + ONE_CNT;
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign expired = enable & (wd_cnt_q == LAST_CNT);

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one single-port slave between two masters using the busy
//   handshake (request -> slave busy rises -> transfer done when busy falls).
//   Round-robin on ties, grant locked for the whole transaction, and a
//   watchdog that errors out a request the slave never acknowledges.
// Ports:
//   clock, reset               clock and synchronous active-high reset
//   mN_rd_en/mN_wr_en          master N read/write request
//   mN_addr/wr_data/byte_en    master N transfer attributes
//   mN_busy                    slave busy, routed to the granted master only
//   mN_error                   one-cycle pulse on watchdog timeout
//   rd_data                    slave read data, broadcast to both masters
//   s_*                        slave-side request, attributes and response
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int ADDR_SIZE = 32,
  parameter int BYTE_NUM  = DATA_SIZE / 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 m0_rd_en,
  input  logic                 m0_wr_en,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [DATA_SIZE-1:0] m0_wr_data,
  input  logic [BYTE_NUM-1:0]  m0_byte_en,
  output logic                 m0_busy,
  output logic                 m0_error,
  input  logic                 m1_rd_en,
  input  logic                 m1_wr_en,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [DATA_SIZE-1:0] m1_wr_data,
  input  logic [BYTE_NUM-1:0]  m1_byte_en,
  output logic                 m1_busy,
  output logic                 m1_error,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 s_rd_en,
  output logic                 s_wr_en,
  output logic [ADDR_SIZE-1:0] s_addr,
  output logic [DATA_SIZE-1:0] s_wr_data,
  output logic [BYTE_NUM-1:0]  s_byte_en,
  input  logic [DATA_SIZE-1:0] s_rd_data,
  input  logic                 s_busy
);

  arb_state_e state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;

  logic req0_s, req1_s, req_gnt_s;
  logic sel_rd_s, sel_wr_s;
  logic fwd_en_s;     // forward the granted master's enables to the slave
  logic fwd_busy_s;   // route s_busy back to the granted master
  logic err_s;        // timeout pulse for the granted master
  logic wd_clear_s, wd_enable_s, wd_expired_s;

  assign req0_s    = req_of(m0_rd_en, m0_wr_en);
  assign req1_s    = req_of(m1_rd_en, m1_wr_en);
  assign req_gnt_s = gnt_q ? req1_s : req0_s;
  assign sel_rd_s  = gnt_q ? m1_rd_en : m0_rd_en;
  assign sel_wr_s  = gnt_q ? m1_wr_en : m0_wr_en;

  // Watchdog only runs in REQ; it restarts from zero whenever REQ is left.
  assign wd_enable_s = (state_q == REQ);
  assign wd_clear_s  = (state_d != REQ);

  watchdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // Next-state, grant and forwarding control.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    fwd_en_s   = 1'b0;
    fwd_busy_s = 1'b0;
    err_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_s && req1_s) begin
          gnt_d   = ~last_q;
          state_d = REQ;
        end else if (req0_s) begin
          gnt_d   = 1'b0;
          state_d = REQ;
        end else if (req1_s) begin
          gnt_d   = 1'b1;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        fwd_en_s   = 1'b1;
        fwd_busy_s = 1'b1;
        if (s_busy) begin
          state_d = BUSY;
        end else if (!req_gnt_s) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end else if (wd_expired_s) begin
          // Enables are withdrawn in the error cycle itself.
          fwd_en_s = 1'b0;
          err_s    = 1'b1;
          last_d   = gnt_q;
          state_d  = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      BUSY: begin
        fwd_en_s   = 1'b1;
        fwd_busy_s = 1'b1;
        if (!s_busy) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end else if (!req_gnt_s) begin
          state_d = DRAIN;
        end else begin
          state_d = BUSY;
        end
      end
      DRAIN: begin
        if (!s_busy) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and round-robin history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign s_rd_en   = fwd_en_s & sel_rd_s;
  assign s_wr_en   = fwd_en_s & wr_qualify(sel_rd_s, sel_wr_s);
  assign s_addr    = gnt_q ? m1_addr    : m0_addr;
  assign s_wr_data = gnt_q ? m1_wr_data : m0_wr_data;
  assign s_byte_en = gnt_q ? m1_byte_en : m0_byte_en;
  assign rd_data   = s_rd_data;

  assign m0_busy  = fwd_busy_s & ~gnt_q & s_busy;
  assign m1_busy  = fwd_busy_s &  gnt_q & s_busy;
  assign m0_error = err_s & ~gnt_q;
  assign m1_error = err_s &  gnt_q;

endmodule
